// File: rtl/ddr_wr_arbiter_4ch_if.sv
// Bus bundle between the four sampler buffers, the arbiter and the DDR write port.
// The master side is the arbiter; the slave side is the sampler/DDR environment.
interface ddr_wr_arbiter_4ch_if #(
  parameter int DQ_WIDTH       = 32,
  parameter int RD_ADDR_LEN    = 5,
  parameter int AXI_ADDR_WIDTH = 28
);
  localparam int BW = DQ_WIDTH * 8;

  logic [3:0]                ch_ready;
  logic [3:0]                ch_frame_end;
  logic [4*BW-1:0]           ch_rd_data;
  logic [RD_ADDR_LEN-1:0]    ch_rd_addr;
  logic [3:0]                ch_rd_valid;
  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [7:0]                axi_awlen;
  logic [3:0]                axi_awid;
  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [BW-1:0]             axi_wdata;
  logic                      axi_wvalid;
  logic                      axi_wlast;
  logic                      axi_wready;
  logic [3:0]                frame_done;
  logic                      busy;

  modport master (
    input  ch_ready, ch_frame_end, ch_rd_data,
    input  axi_awready, axi_wready,
    output ch_rd_addr, ch_rd_valid,
    output axi_awaddr, axi_awlen, axi_awid, axi_awvalid,
    output axi_wdata, axi_wvalid, axi_wlast,
    output frame_done, busy
  );

  modport slave (
    output ch_ready, ch_frame_end, ch_rd_data,
    output axi_awready, axi_wready,
    input  ch_rd_addr, ch_rd_valid,
    input  axi_awaddr, axi_awlen, axi_awid, axi_awvalid,
    input  axi_wdata, axi_wvalid, axi_wlast,
    input  frame_done, busy
  );
endinterface

// File: rtl/ddr_wr_arbiter_4ch.sv
// Round-robin 4-channel half-buffer reader issuing 16-beat DDR write bursts.
// Reads are prefetched into a 2-entry skid FIFO with a bypass for the empty case.
module ddr_wr_arbiter_4ch #(
  parameter int DQ_WIDTH       = 32,
  parameter int RD_ADDR_LEN    = 5,
  parameter int BURST_LEN      = 16,
  parameter int AXI_ADDR_WIDTH = 28,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR   = 28'h0,
  parameter logic [AXI_ADDR_WIDTH-1:0] REGION_SIZE = 28'h0020000,
  parameter int FRAME_BURSTS   = 225
) (
  input logic clk,
  input logic rst,
  ddr_wr_arbiter_4ch_if.master bus
);
  localparam int BW  = DQ_WIDTH * 8;
  localparam int BCW = $clog2(FRAME_BURSTS);
  localparam int BLW = $clog2(BURST_LEN);
  localparam int CW  = BLW + 1;
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BSTRIDE = AW'(BURST_LEN * DQ_WIDTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state_q, state_d;

  logic [3:0]             rdy_q, req_pend, frame_rst_pend, half;
  logic [BCW-1:0]         burst_cnt [4];
  logic [1:0]             rr_ptr, g, gnt, idx;
  logic                   gnt_ok, grant;
  logic [RD_ADDR_LEN-1:0] rd_addr;
  logic [CW-1:0]          rd_cnt, wr_cnt;
  logic                   infl, issue, push, pop, fifo_pop, wvalid, last;
  logic [BW-1:0]          fifo [2];
  logic                   wp, rp;
  logic [1:0]             fcnt;
  logic [BW-1:0]          rd_data_g;
  logic [3:0]             svc, done_g, fdone;

  // lowest offset from rr_ptr wins, so scan from the far end
  always_comb begin
    gnt_ok = 1'b0;
    gnt    = rr_ptr;
    idx    = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req_pend[idx]) begin
        gnt_ok = 1'b1;
        gnt    = idx;
      end
    end
  end

  assign grant     = (state_q == IDLE) && gnt_ok;
  assign rd_data_g = bus.ch_rd_data[int'(g)*BW +: BW];
  assign wvalid    = (state_q == DATA) && ((fcnt != 2'd0) || infl);
  assign pop       = wvalid && bus.axi_wready;
  assign fifo_pop  = pop && (fcnt != 2'd0);
  assign push      = infl && !((fcnt == 2'd0) && pop);
  assign last      = (wr_cnt == CW'(BURST_LEN - 1));
  assign issue     = ((state_q == ADDR) || (state_q == DATA)) &&
                     (rd_cnt < CW'(BURST_LEN)) &&
                     (({1'b0, fcnt} + {2'b0, infl}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    svc    = '0;
    done_g = '0;
    fdone  = '0;
    for (int i = 0; i < 4; i++) begin
      svc[i]    = ((state_q != IDLE) && (g == 2'(i))) ||
                  (grant && (gnt == 2'(i)));
      done_g[i] = (state_q == DONE) && (g == 2'(i));
    end
    if ((state_q == DONE) && !frame_rst_pend[g] &&
        (burst_cnt[g] == BCW'(FRAME_BURSTS - 1)))
      fdone[g] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_ok) state_d = ADDR;
      ADDR: if (bus.axi_awready) state_d = DATA;
      DATA: if (pop && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q          <= '0;
      req_pend       <= '0;
      frame_rst_pend <= '0;
      half           <= '0;
      rr_ptr         <= '0;
      g              <= '0;
      rd_addr        <= '0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      infl           <= 1'b0;
      wp             <= 1'b0;
      rp             <= 1'b0;
      fcnt           <= '0;
      for (int i = 0; i < 4; i++) burst_cnt[i] <= '0;
    end else begin
      rdy_q    <= bus.ch_ready;
      req_pend <= (req_pend & ~(grant ? (4'd1 << gnt) : 4'd0)) |
                  (bus.ch_ready & ~rdy_q);
      if (grant) begin
        g       <= gnt;
        rr_ptr  <= gnt + 2'd1;
        rd_addr <= RD_ADDR_LEN'({half[gnt], {BLW{1'b0}}});
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
      end
      infl <= issue;
      if (push) begin
        fifo[wp] <= rd_data_g;
        wp       <= ~wp;
      end
      if (fifo_pop) rp <= ~rp;
      fcnt <= fcnt + {1'b0, push} - {1'b0, fifo_pop};
      if (pop) wr_cnt <= wr_cnt + 1'b1;
      // resync clears immediately when idle, otherwise at the end of the burst
      for (int i = 0; i < 4; i++) begin
        if (done_g[i]) begin
          if (frame_rst_pend[i]) begin
            burst_cnt[i] <= '0;
            half[i]      <= 1'b0;
          end else begin
            half[i] <= ~half[i];
            if (burst_cnt[i] == BCW'(FRAME_BURSTS - 1))
              burst_cnt[i] <= '0;
            else
              burst_cnt[i] <= burst_cnt[i] + 1'b1;
          end
        end else if (!svc[i] && frame_rst_pend[i]) begin
          burst_cnt[i] <= '0;
          half[i]      <= 1'b0;
        end
        frame_rst_pend[i] <= bus.ch_frame_end[i] |
                             (frame_rst_pend[i] & svc[i] & ~done_g[i]);
      end
    end
  end

  always_comb begin
    bus.ch_rd_addr  = rd_addr;
    bus.ch_rd_valid = (state_q != IDLE) ? (4'd1 << g) : 4'd0;
    bus.axi_awvalid = (state_q == ADDR);
    bus.axi_awaddr  = '0;
    bus.axi_awid    = '0;
    if (state_q == ADDR) begin
      bus.axi_awaddr = BASE_ADDR + AW'(g) * REGION_SIZE +
                       AW'(burst_cnt[g]) * BSTRIDE;
      bus.axi_awid   = {2'b00, g};
    end
    bus.axi_awlen  = 8'(BURST_LEN - 1);
    bus.axi_wvalid = wvalid;
    bus.axi_wlast  = wvalid && last;
    bus.axi_wdata  = '0;
    if (wvalid)
      bus.axi_wdata = (fcnt != 2'd0) ? fifo[rp] : rd_data_g;
    bus.frame_done = fdone;
    bus.busy       = (state_q != IDLE);
  end
endmodule

// File: tb/tb_ddr_wr_arbiter_4ch.sv
// Randomized bench for ddr_wr_arbiter_4ch against a burst-level reference model.
// The model predicts grant order, burst addresses, buffer halves and frame wraps.
module tb_ddr_wr_arbiter_4ch;
  logic clk = 1'b0;
  logic rst;

  ddr_wr_arbiter_4ch_if bus ();

  ddr_wr_arbiter_4ch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [255:0] mem [4][32];

  int aw_pct = 100;
  int wr_pct = 100;
  bit aw_force0 = 1'b0;

  logic [27:0]  aw_addr_q [$];
  logic [3:0]   aw_id_q [$];
  int           aw_cyc_q [$];
  logic [255:0] w_data_q [$];
  logic         w_last_q [$];
  int           w_cyc_q [$];
  int           fd_cnt [4];

  int rr;
  int cnt [4];
  int hf [4];
  int exp_fd [4];
  int exp_ch [$];
  int exp_addr [$];
  int exp_half [$];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sampler buffers: synchronous read, one cycle latency
  always @(posedge clk)
    for (int c = 0; c < 4; c++)
      bus.ch_rd_data[c*256 +: 256] <= mem[c][bus.ch_rd_addr];

  initial begin
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.axi_awready = !aw_force0 && (int'($urandom_range(99)) < aw_pct);
      bus.axi_wready  = int'($urandom_range(99)) < wr_pct;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.axi_awvalid && bus.axi_awready) begin
        aw_addr_q.push_back(bus.axi_awaddr);
        aw_id_q.push_back(bus.axi_awid);
        aw_cyc_q.push_back(cyc);
      end
      if (bus.axi_wvalid && bus.axi_wready) begin
        w_data_q.push_back(bus.axi_wdata);
        w_last_q.push_back(bus.axi_wlast);
        w_cyc_q.push_back(cyc);
      end
      for (int c = 0; c < 4; c++)
        if (bus.frame_done[c]) fd_cnt[c]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    aw_addr_q.delete();
    aw_id_q.delete();
    aw_cyc_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    w_cyc_q.delete();
    exp_ch.delete();
    exp_addr.delete();
    exp_half.delete();
  endtask

  task automatic model_reset();
    rr = 0;
    for (int c = 0; c < 4; c++) begin
      cnt[c] = 0;
      hf[c] = 0;
      exp_fd[c] = 0;
      fd_cnt[c] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".awvalid"}, bus.axi_awvalid, 0);
    chk({tag, ".awaddr"}, bus.axi_awaddr, 0);
    chk({tag, ".awid"}, bus.axi_awid, 0);
    chk({tag, ".awlen"}, bus.axi_awlen, 15);
    chk({tag, ".wvalid"}, bus.axi_wvalid, 0);
    chk({tag, ".wlast"}, bus.axi_wlast, 0);
    chk({tag, ".wdata"}, bus.axi_wdata, 0);
    chk({tag, ".rd_addr"}, bus.ch_rd_addr, 0);
    chk({tag, ".rd_valid"}, bus.ch_rd_valid, 0);
    chk({tag, ".frame_done"}, bus.frame_done, 0);
    chk({tag, ".busy"}, bus.busy, 0);
  endtask

  task automatic do_reset(input string tag);
    bus.ch_ready = '0;
    bus.ch_frame_end = '0;
    rst = 1'b1;
    step();
    @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
    clear_obs();
    model_reset();
    step();
  endtask

  // all requests of one call are pending together, so they drain in rr order
  task automatic issue(input logic [3:0] m);
    int c;
    int lst;
    lst = -1;
    for (int k = 0; k < 4; k++) begin
      c = (rr + k) % 4;
      if (m[c]) begin
        exp_ch.push_back(c);
        exp_addr.push_back(c * 'h20000 + cnt[c] * 512);
        exp_half.push_back(hf[c]);
        hf[c] ^= 1;
        cnt[c]++;
        if (cnt[c] == 225) begin
          cnt[c] = 0;
          exp_fd[c]++;
        end
        lst = c;
      end
    end
    if (lst >= 0) rr = (lst + 1) % 4;
    bus.ch_ready = m;
    step();
    bus.ch_ready = '0;
  endtask

  task automatic resync(input int c);
    cnt[c] = 0;
    hf[c] = 0;
  endtask

  task automatic pulse_fe(input logic [3:0] m);
    bus.ch_frame_end = m;
    step();
    bus.ch_frame_end = '0;
  endtask

  task automatic drain(input bit tp);
    int n;
    bit ok;
    int c;
    int ix;
    n = exp_ch.size();
    ok = 1'b0;
    for (int i = 0; i < 600 * n + 50; i++) begin
      @(negedge clk);
      if (w_data_q.size() >= 16 * n && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
    chk("aw_count", aw_addr_q.size(), n);
    chk("w_count", w_data_q.size(), 16 * n);
    if (ok && aw_addr_q.size() == n && w_data_q.size() == 16 * n) begin
      for (int k = 0; k < n; k++) begin
        c = exp_ch[k];
        chk("awaddr", aw_addr_q[k], exp_addr[k]);
        chk("awid", aw_id_q[k], c);
        for (int b = 0; b < 16; b++) begin
          ix = 16 * k + b;
          chk("wdata", w_data_q[ix], mem[c][exp_half[k] * 16 + b]);
          chk("wlast", w_last_q[ix], b == 15);
        end
        if (tp) begin
          chk("first_beat_lat", w_cyc_q[16 * k] - aw_cyc_q[k], 1);
          chk("beat_span", w_cyc_q[16 * k + 15] - w_cyc_q[16 * k], 15);
        end
      end
    end
    for (int f = 0; f < 4; f++)
      chk("frame_done_cnt", fd_cnt[f], exp_fd[f]);
    clear_obs();
  endtask

  initial begin
    bit seen;
    logic [3:0] m;
    int pick [3];
    pick[0] = 100;
    pick[1] = 60;
    pick[2] = 30;
    rst = 1'b1;
    bus.ch_ready = '0;
    bus.ch_frame_end = '0;
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 32; e++)
        for (int w = 0; w < 8; w++)
          mem[c][e][w*32 +: 32] = $urandom;
    step();
    do_reset("reset");

    // single channel, two halves, full-rate throughput
    issue(4'b0100);
    drain(1'b1);
    issue(4'b0100);
    drain(1'b1);

    // simultaneous requests from rr_ptr=0
    do_reset("reset2");
    issue(4'b1111);
    drain(1'b1);

    // resync while channel 1 is in service
    issue(4'b0010);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aw_addr_q.size() >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fe_aw_wait", seen, 1);
    pulse_fe(4'b0010);
    resync(1);
    drain(1'b0);
    issue(4'b0010);
    drain(1'b0);

    // delayed awready: address phase held stable, no data early
    aw_force0 = 1'b1;
    issue(4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.axi_awvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("awvalid_wait", seen, 1);
    for (int i = 0; i < 10; i++) begin
      chk("aw_hold_valid", bus.axi_awvalid, 1);
      chk("aw_hold_addr", bus.axi_awaddr, exp_addr[0]);
      chk("aw_hold_nowv", bus.axi_wvalid, 0);
      if (i == 9) aw_force0 = 1'b0;
      @(negedge clk);
    end
    chk("aw_last_valid", bus.axi_awvalid, 1);
    chk("aw_last_ready", bus.axi_awready, 1);
    chk("aw_last_addr", bus.axi_awaddr, exp_addr[0]);
    chk("aw_last_nowv", bus.axi_wvalid, 0);
    drain(1'b0);

    // randomized episodes with backpressure and idle resyncs
    for (int ep = 0; ep < 40; ep++) begin
      aw_pct = pick[$urandom_range(2)];
      wr_pct = pick[$urandom_range(2)];
      if ($urandom_range(2) == 0) begin
        m = 4'($urandom_range(15, 1));
        pulse_fe(m);
        for (int c = 0; c < 4; c++)
          if (m[c]) resync(c);
      end
      issue(4'($urandom_range(15, 1)));
      drain(1'b0);
    end

    // reset in the middle of a burst
    wr_pct = 50;
    aw_pct = 100;
    issue(4'b0100);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (w_data_q.size() >= 5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_wait", seen, 1);
    do_reset("midrst");

    // full frame on channel 0, then wrap to the region base
    wr_pct = 100;
    for (int b = 0; b < 226; b++) begin
      issue(4'b0001);
      drain(1'b0);
    end
    chk("frame_done_total", fd_cnt[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
